clk_div_prog: RTL and testbench

Runtime-programmable clock divider that derives a divided clock `clk_out` and a one-cycle period strobe `tick` from the system clock. The divisor is loaded on the fly through a small load/busy handshake and takes effect only at a period boundary, so `clk_out` never produces a runt pulse. It sits beside the processor clock tree and provides slow clocks and strobes for peripherals, timers and the display/IO blocks.

---
 rtl/clk_div_prog_if.sv | 23 ++
 rtl/clk_div_prog.sv | 94 +++++++++
 tb/tb_clk_div_prog.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_prog_if.sv
// Load/busy handshake and divided-clock outputs of clk_div_prog.
// master drives enable and divisor loads; slave is the divider.
interface clk_div_prog_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             div_busy;
  logic [WIDTH-1:0] div_cur;
  logic             clk_out;
  logic             tick;

  modport master (
    output en, div_in, div_load,
    input  div_busy, div_cur, clk_out, tick
  );

  modport slave (
    input  en, div_in, div_load,
    output div_busy, div_cur, clk_out, tick
  );
endinterface

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider with glitch-free divisor reload.
// Optional CLK_DIV_ODD_DUTY_EN adds a negedge flop for 50% odd duty.
module clk_div_prog #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input logic          clk,
  input logic          reset,
  clk_div_prog_if.slave bus
);

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] MIN = WIDTH'(2);

  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             hi_q, hi_d;
  logic             tick_q, tick_d;

  logic             wrap;
  logic [WIDTH-1:0] clamped;
  logic [WIDTH:0]   half_d;

  assign wrap    = (cnt_q == (div_q - WIDTH'(1)));
  assign clamped = (bus.div_in < MIN) ? MIN : bus.div_in;
  assign half_d  = ({1'b0, div_d} + (WIDTH+1)'(1)) >> 1;

  // Next state: count, apply pending divisor at wrap, accept loads.
  always_comb begin
    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    tick_d   = 1'b0;
    if (bus.en) begin
      if (wrap) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (pend_v_q) begin
          div_d    = pend_q;
          pend_v_d = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      if (bus.div_load) begin
        pend_d   = clamped;
        pend_v_d = 1'b1;
      end
      hi_d = ({1'b0, cnt_d} < half_d);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= DEF;
      pend_q   <= DEF;
      pend_v_q <= 1'b0;
      cnt_q    <= DEF - WIDTH'(1);
      hi_q     <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      tick_q   <= tick_d;
    end
  end

`ifdef CLK_DIV_ODD_DUTY_EN
  logic hi_n;

  // Half-cycle delayed high phase trims odd divisors to exact 50%.
  always_ff @(negedge clk) begin
    if (reset) hi_n <= 1'b0;
    else       hi_n <= hi_q;
  end

  assign bus.clk_out = div_q[0] ? (hi_q & hi_n) : hi_q;
`else
  assign bus.clk_out = hi_q;
`endif

  assign bus.tick     = tick_q;
  assign bus.div_busy = pend_v_q;
  assign bus.div_cur  = div_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: per-cycle scoreboard of a period
// model plus directed checks on spacing, duty, clamping and reloads.
module tb_clk_div_prog;

  localparam int W   = 8;
  localparam int DEF = 3;

  typedef struct {
    logic         tick;
    logic         clk;
    logic         busy;
    logic [W-1:0] cur;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  clk_div_prog_if #(.WIDTH(W)) bus();

  clk_div_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int nerr = 0;
  int nchk = 0;

  int m_div = DEF;
  int m_pos = DEF - 1;
  int m_pd  = DEF;
  bit m_pv  = 1'b0;
  bit m_hi  = 1'b0;
  bit m_tick = 1'b0;

  exp_t sb[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the period model by one posedge and queue its outputs.
  task automatic model_push();
    bit   prev_hi;
    bit   bnd;
    exp_t e;
    prev_hi = m_hi;
    if (reset) begin
      m_div  = DEF;
      m_pos  = DEF - 1;
      m_pv   = 1'b0;
      m_hi   = 1'b0;
      m_tick = 1'b0;
    end else if (bus.en) begin
      bnd = (m_pos == m_div - 1);
      if (bnd) begin
        m_pos = 0;
        if (m_pv) begin
          m_div = m_pd;
          m_pv  = 1'b0;
        end
      end else begin
        m_pos++;
      end
      if (bus.div_load) begin
        m_pd = (bus.div_in < 2) ? 2 : int'(bus.div_in);
        m_pv = 1'b1;
      end
      m_hi   = (2 * m_pos < m_div);
      m_tick = bnd;
    end else begin
      m_tick = 1'b0;
    end
    e.tick = m_tick;
    e.busy = m_pv;
    e.cur  = W'(m_div);
`ifdef CLK_DIV_ODD_DUTY_EN
    e.clk  = (m_div % 2 == 1) ? (m_hi & prev_hi) : m_hi;
`else
    e.clk  = m_hi;
`endif
    sb.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_tick", bus.tick, e.tick);
    chk("sb_clk_out", bus.clk_out, e.clk);
    chk("sb_busy", bus.div_busy, e.busy);
    chk("sb_cur", bus.div_cur, e.cur);
  endtask

  task automatic wait_cur(int v);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (bus.div_cur == W'(v)) break;
    end
    chk("wait_cur", bus.div_cur, v);
  endtask

  initial begin
    int n;
    int hi;
    bit seen5;

    bus.en       = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
    reset        = 1'b1;
    cycle();
    cycle();
    chk("rst_cur", bus.div_cur, DEF);
    chk("rst_busy", bus.div_busy, 0);
    chk("rst_clk", bus.clk_out, 0);
    chk("rst_tick", bus.tick, 0);

    reset  = 1'b0;
    bus.en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      chk("tick_div3", bus.tick, (i % 3 == 1));
    end

    bus.div_load = 1'b1;
    bus.div_in   = 8'd8;
    cycle();
    bus.div_load = 1'b0;
    chk("load8_busy", bus.div_busy, 1);
    cycle();
    chk("load8_cur_old", bus.div_cur, 3);
    cycle();
    chk("load8_cur_new", bus.div_cur, 8);
    chk("load8_busy_drop", bus.div_busy, 0);
    chk("load8_tick", bus.tick, 1);
    n  = 0;
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n++;
      if (bus.clk_out) hi++;
      if (bus.tick) break;
    end
    chk("div8_span", n, 8);
    chk("div8_high", hi, 4);

    bus.div_load = 1'b1;
    bus.div_in   = 8'd0;
    cycle();
    bus.div_in   = 8'd1;
    cycle();
    bus.div_load = 1'b0;
    chk("clamp_busy", bus.div_busy, 1);
    wait_cur(2);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("div2_clk", bus.clk_out, (i % 2 == 1));
      chk("div2_tick", bus.tick, (i % 2 == 1));
    end

    cycle();
    bus.div_load = 1'b1;
    bus.div_in   = 8'd5;
    cycle();
    bus.div_in   = 8'd6;
    cycle();
    bus.div_load = 1'b0;
    seen5 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (bus.div_cur == 8'd5) seen5 = 1'b1;
      if (bus.div_cur == 8'd6) break;
    end
    chk("last_wins_cur", bus.div_cur, 6);
    chk("last_wins_busy", bus.div_busy, 0);
    chk("never_five", seen5, 0);

    bus.div_load = 1'b1;
    bus.div_in   = 8'd4;
    cycle();
    bus.div_load = 1'b0;
    wait_cur(4);
    cycle();
    bus.en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("stall_clk", bus.clk_out, 1);
      chk("stall_tick", bus.tick, 0);
    end
    bus.en = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n++;
      if (bus.tick) break;
    end
    chk("stall_span", 1 + 5 + n, 9);

    cycle();
    bus.div_load = 1'b1;
    bus.div_in   = 8'd7;
    cycle();
    bus.div_load = 1'b0;
    chk("pre_rst_busy", bus.div_busy, 1);
    reset = 1'b1;
    cycle();
    chk("mid_rst_cur", bus.div_cur, DEF);
    chk("mid_rst_busy", bus.div_busy, 0);
    chk("mid_rst_clk", bus.clk_out, 0);
    chk("mid_rst_tick", bus.tick, 0);
    reset = 1'b0;
    cycle();
    chk("post_rst_tick", bus.tick, 1);
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
